// File: rtl/sextium_pkg.sv
// Shared definitions for the Sextium CPU control path and datapath.
// Holds the 4-bit opcode map (Sextium encoding 0-13 plus HALT and the
// reserved illegal opcode), the controller state enum and the encodings of
// every datapath select driven by slot_controller.
package sextium_pkg;

    // Opcodes 0-13 keep the original Sextium encoding.
    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_SYSCALL = 4'd1;
    localparam logic [3:0] OP_LOAD    = 4'd2;
    localparam logic [3:0] OP_STORE   = 4'd3;
    localparam logic [3:0] OP_SWAPA   = 4'd4;
    localparam logic [3:0] OP_SWAPD   = 4'd5;
    localparam logic [3:0] OP_BRANCHZ = 4'd6;
    localparam logic [3:0] OP_BRANCHN = 4'd7;
    localparam logic [3:0] OP_JUMP    = 4'd8;
    localparam logic [3:0] OP_CONST   = 4'd9;
    localparam logic [3:0] OP_ADD     = 4'd10;
    localparam logic [3:0] OP_SUB     = 4'd11;
    localparam logic [3:0] OP_MUL     = 4'd12;
    localparam logic [3:0] OP_DIV     = 4'd13;
    localparam logic [3:0] OP_HALT    = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_IOWAIT,
        ST_DIVWAIT,
        ST_HALT
    } state_t;

    // Memory address source
    localparam logic SELADDR_PC = 1'b0;
    localparam logic SELADDR_AR = 1'b1;

    // ACC write-back source
    localparam logic [1:0] SELACC_MEM  = 2'd0;
    localparam logic [1:0] SELACC_IO   = 2'd1;
    localparam logic [1:0] SELACC_SWAP = 2'd2;
    localparam logic [1:0] SELACC_ALU  = 2'd3;

    // Register exchanged with ACC
    localparam logic SELSWAP_AR = 1'b0;
    localparam logic SELSWAP_DR = 1'b1;

    // PC next-value muxes
    localparam logic SELPC1_NEXT = 1'b0;
    localparam logic SELPC1_REG  = 1'b1;
    localparam logic SELPC2_AR   = 1'b0;
    localparam logic SELPC2_ACC  = 1'b1;

    // ALU operation
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

endpackage

// File: rtl/slot_controller_div_delay.sv
// div_delay: loadable down-counter timing the multi-cycle divide.
//   clock, reset      : clock, synchronous active-low reset
//   load, load_value  : load the counter (dominates counting)
//   done              : counter is zero
// The counter counts down by one per cycle while nonzero and rests at zero.
module div_delay #(
    parameter int LATENCY = 3,
    parameter int CW      = $clog2(LATENCY + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done
);

    logic [CW-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/slot_controller.sv
// slot_controller: control FSM for the Sextium CPU datapath.
// Fetches one instruction word of SLOTS packed opcodes and executes the slots
// in order, driving every datapath select/enable.
//   clock, reset             : clock, synchronous active-low reset
//   insn                     : opcode of the slot selected by curinsn
//   accz, accn               : ACC zero / negative flags
//   iobusy                   : IO unit busy
//   mem_ack                  : memory completes the current access this cycle
//   mem_read .. diven        : datapath strobes (combinational)
//   seladdr .. aluinsn       : datapath selects (combinational)
//   curinsn, halted, illegal : registered slot index and stop status
module slot_controller
    import sextium_pkg::*;
#(
    parameter int SLOTS       = 4,
    parameter int SW          = $clog2(SLOTS),
    parameter int DIV_LATENCY = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    insn,
    input  logic          accz,
    input  logic          accn,
    input  logic          iobusy,
    input  logic          mem_ack,
    output logic          mem_read,
    output logic          mem_write,
    output logic          ir_write,
    output logic          pc_write,
    output logic          acc_write,
    output logic          doswap,
    output logic          runio,
    output logic          diven,
    output logic          seladdr,
    output logic [1:0]    selacc,
    output logic          selswap,
    output logic          selpc1,
    output logic          selpc2,
    output logic [1:0]    aluinsn,
    output logic [SW-1:0] curinsn,
    output logic          halted,
    output logic          illegal
);

    localparam int            CW       = $clog2(DIV_LATENCY + 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

    state_t        state, state_next;
    logic [SW-1:0] slot_next;
    logic          halted_next, illegal_next;
    logic          div_load, div_done;
    logic          last_slot;

    div_delay #(.LATENCY(DIV_LATENCY), .CW(CW)) u_div_delay (
        .clock      (clock),
        .reset      (reset),
        .load       (div_load),
        .load_value (DIV_LOAD),
        .done       (div_done)
    );

    assign last_slot = (curinsn == SW'(SLOTS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_FETCH;
            curinsn <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            curinsn <= slot_next;
            halted  <= halted_next;
            illegal <= illegal_next;
        end
    end

    // Next-state logic. "Advance" relies on SLOTS being a power of two: the
    // slot increment wraps to 0 exactly when the word is exhausted, so FETCH
    // is always entered with curinsn=0.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_next   = state;
        slot_next    = curinsn;
        halted_next  = halted;
        illegal_next = illegal;
        div_load     = 1'b0;

        unique case (state)
            ST_FETCH: begin
                if (mem_ack) begin
                    state_next = ST_DECODE;
                    slot_next  = '0;
                end
            end

            ST_DECODE: begin
                unique case (insn)
                    OP_NOP, OP_SWAPA, OP_SWAPD, OP_ADD, OP_SUB, OP_MUL: begin
                        state_next = last_slot ? ST_FETCH : ST_DECODE;
                        slot_next  = curinsn + SW'(1);
                    end
                    OP_LOAD, OP_STORE, OP_CONST: begin
                        if (mem_ack) begin
                            state_next = last_slot ? ST_FETCH : ST_DECODE;
                            slot_next  = curinsn + SW'(1);
                        end
                    end
                    OP_BRANCHZ, OP_BRANCHN: begin
                        if ((insn == OP_BRANCHZ) ? accz : accn) begin
                            state_next = ST_FETCH;
                            slot_next  = '0;
                        end else begin
                            state_next = last_slot ? ST_FETCH : ST_DECODE;
                            slot_next  = curinsn + SW'(1);
                        end
                    end
                    OP_JUMP: begin
                        state_next = ST_FETCH;
                        slot_next  = '0;
                    end
                    OP_SYSCALL: state_next = ST_IOWAIT;
                    OP_DIV: begin
                        state_next = ST_DIVWAIT;
                        div_load   = 1'b1;
                    end
                    OP_HALT: begin
                        state_next  = ST_HALT;
                        halted_next = 1'b1;
                    end
                    default: begin
                        state_next   = ST_HALT;
                        halted_next  = 1'b1;
                        illegal_next = 1'b1;
                    end
                endcase
            end

            ST_IOWAIT: begin
                if (!iobusy) begin
                    state_next = last_slot ? ST_FETCH : ST_DECODE;
                    slot_next  = curinsn + SW'(1);
                end
            end

            ST_DIVWAIT: begin
                if (div_done) begin
                    state_next = last_slot ? ST_FETCH : ST_DECODE;
                    slot_next  = curinsn + SW'(1);
                end
            end

            ST_HALT: state_next = ST_HALT;

            default: state_next = ST_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        acc_write = 1'b0;
        doswap    = 1'b0;
        runio     = 1'b0;
        diven     = 1'b0;
        seladdr   = SELADDR_PC;
        selacc    = SELACC_MEM;
        selswap   = SELSWAP_AR;
        selpc1    = SELPC1_NEXT;
        selpc2    = SELPC2_AR;
        aluinsn   = ALU_ADD;

        unique case (state)
            ST_FETCH: begin
                mem_read = 1'b1;
                seladdr  = SELADDR_PC;
                ir_write = mem_ack;
                pc_write = mem_ack;
            end

            ST_DECODE: begin
                unique case (insn)
                    OP_LOAD: begin
                        mem_read  = 1'b1;
                        seladdr   = SELADDR_AR;
                        selacc    = SELACC_MEM;
                        acc_write = mem_ack;
                    end
                    OP_STORE: begin
                        mem_write = 1'b1;
                        seladdr   = SELADDR_AR;
                    end
                    OP_CONST: begin
                        mem_read  = 1'b1;
                        seladdr   = SELADDR_PC;
                        selacc    = SELACC_MEM;
                        acc_write = mem_ack;
                        pc_write  = mem_ack;
                    end
                    OP_SWAPA, OP_SWAPD: begin
                        doswap    = 1'b1;
                        selacc    = SELACC_SWAP;
                        acc_write = 1'b1;
                        selswap   = (insn == OP_SWAPD) ? SELSWAP_DR : SELSWAP_AR;
                    end
                    OP_ADD, OP_SUB, OP_MUL: begin
                        selacc    = SELACC_ALU;
                        acc_write = 1'b1;
                        aluinsn   = (insn == OP_ADD) ? ALU_ADD :
                                    (insn == OP_SUB) ? ALU_SUB : ALU_MUL;
                    end
                    OP_BRANCHZ, OP_BRANCHN: begin
                        if ((insn == OP_BRANCHZ) ? accz : accn) begin
                            pc_write = 1'b1;
                            selpc1   = SELPC1_REG;
                            selpc2   = SELPC2_AR;
                        end
                    end
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        selpc1   = SELPC1_REG;
                        selpc2   = SELPC2_ACC;
                    end
                    OP_SYSCALL: begin
                        runio  = 1'b1;
                        selacc = SELACC_IO;
                    end
                    OP_DIV: begin
                        aluinsn = ALU_DIV;
                        diven   = 1'b1;
                    end
                    default: ;  // NOP, HALT, illegal: no strobes
                endcase
            end

            ST_IOWAIT: begin
                selacc = SELACC_IO;
                runio  = iobusy;
            end

            ST_DIVWAIT: begin
                aluinsn   = ALU_DIV;
                selacc    = SELACC_ALU;
                diven     = 1'b1;
                acc_write = div_done;
            end

            default: ;  // HALT: everything stays at its default
        endcase
    end

endmodule

// File: doc/slot_controller.md
# slot_controller

Parametrised control FSM for the Sextium CPU datapath. It fetches one instruction word holding SLOTS packed opcodes and executes the slots in order. It drives all datapath selects and enables: memory, IR, PC, ACC, swap, ALU and IO. It handles memory, IO and multi-cycle divide waits, and adds HALT and illegal-opcode handling.

## Interface
- SLOTS, 4: opcodes per instruction word; power of two, ≥2.
- SW, $clog2(SLOTS): slot index width (derived).
- DIV_LATENCY, 3: divide cycles spent in DIVWAIT; ≥1.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- insn  in  4  opcode of current slot, selected from IR by `curinsn`.
- accz / accn  in  1  ACC zero / ACC negative.
- iobusy  in  1  IO unit busy.
- mem_ack  in  1  memory completes the current read/write this cycle.
- mem_read, mem_write, ir_write, pc_write, acc_write, doswap, runio, diven  out  1  strobes.
- seladdr  out  1  0 PC, 1 AR.
- selacc  out  2  0 MEM, 1 IO, 2 SWAP, 3 ALU.
- selswap  out  1  0 AR, 1 DR.
- selpc1  out  1  0 next, 1 reg.
- selpc2  out  1  0 AR, 1 ACC.
- aluinsn  out  2  0 add, 1 sub, 2 mul, 3 div.
- curinsn  out  SW  slot index (registered).
- halted  out  1  core stopped (registered).
- illegal  out  1  stopped on opcode 15 (registered).

## Operation
- States: FETCH, DECODE, IOWAIT, DIVWAIT, HALT. Opcodes 0–13 keep Sextium encoding; 14 HALT; 15 illegal.
- All strobes and selects are combinational from state, insn, flags and ack. Every output has a default of 0 in every state (no latches); selpc2 included.
- FETCH: mem_read=1, seladdr=PC. ir_write=pc_write=mem_ack. On ack: curinsn←0, go to DECODE.
- "Advance" means: if curinsn==SLOTS-1, go to FETCH; otherwise curinsn+1 and stay in DECODE.
- DECODE, by opcode:
  - NOP: advance.
  - LOAD: mem_read, seladdr=AR, selacc=MEM, acc_write=mem_ack. Hold the slot until ack, then advance.
  - STORE: mem_write, seladdr=AR. Hold the slot until ack, then advance.
  - CONST: mem_read, seladdr=PC, selacc=MEM. acc_write=pc_write=mem_ack. Hold until ack, then advance.
  - SWAPA/SWAPD: doswap, selacc=SWAP, acc_write. selswap=0 for SWAPA, 1 for SWAPD.
  - ADD/SUB/MUL: selacc=ALU, acc_write, aluinsn 0/1/2.
  - BRANCHZ/BRANCHN: if the flag is set, pc_write, selpc1=1, selpc2=AR, and go to FETCH (remaining slots discarded). Otherwise advance.
  - JUMP: pc_write, selpc1=1, selpc2=ACC, go to FETCH.
  - SYSCALL: runio=1, selacc=IO, go to IOWAIT.
  - DIV: aluinsn=3, diven=1, load counter with DIV_LATENCY-1, go to DIVWAIT.
  - HALT: go to HALT with halted=1.
  - 15: go to HALT with halted=1 and illegal=1.
- IOWAIT: selacc=IO, runio=iobusy. When iobusy=0, advance.
- DIVWAIT: aluinsn=3, selacc=ALU, diven=1. Counter decrements each cycle. At 0: acc_write=1, then advance.
- HALT: all strobes 0; the state is held until reset.

## Timing
- Reset (reset=0 at an edge): state=FETCH, curinsn=0, counter=0, halted=0, illegal=0. Reset dominates all events, including mid-DIV and mid-IO.
- The cycle after reset, the outputs are FETCH outputs: mem_read=1, everything else 0 until ack.
- Single-cycle ops take 1 DECODE cycle. A memory op takes ≥1 cycle, completing in the ack cycle.
- DIV takes 1 DECODE cycle plus DIV_LATENCY DIVWAIT cycles. acc_write fires exactly once, in the last DIVWAIT cycle.
- SYSCALL takes 1 DECODE cycle plus ≥1 IOWAIT cycle.
- Best-case word: 1 fetch cycle plus SLOTS decode cycles.
- Taken branch or JUMP in any slot: the next cycle is FETCH with curinsn=0.
- mem_ack outside a memory request is ignored.

## Structure
- Package `sextium_pkg`: opcode constants (incl. HALT=14, ILLEGAL=15), state enum, and SELADDR/SELACC/SELSWAP/SELPC/ALU-op constants. The datapath shares this package.
- One sub-module, `div_delay`: a loadable down-counter with a done flag, width $clog2(DIV_LATENCY+1).

## Test plan
- Reset, then word {ADD,SUB,MUL,NOP}, ack in cycle 1 → 1 FETCH cycle, 4 DECODE cycles, aluinsn 0,1,2. acc_write high in 3 cycles. Returns to FETCH with curinsn=0.
- FETCH with ack delayed 3 cycles → mem_read high for 4 cycles. pc_write and ir_write high only in the ack cycle.
- Slot 1 BRANCHZ with accz=1 → pc_write, selpc1=1, selpc2=0. Slots 2–3 are never decoded. Repeat with accz=0 → slot 2 executes.
- DIV in slot 3 with DIV_LATENCY=5 → 5 DIVWAIT cycles, acc_write only in the 5th, then FETCH.
- SYSCALL with iobusy high for 4 cycles → runio high through busy. DECODE resumes at the next slot.
- Opcode 15 in slot 2 → halted=illegal=1 and all strobes 0 for 20 cycles. reset=0 clears both and restarts FETCH.
